comparator_32x2: RTL and testbench

COMPARATOR_32X2 -- requirements
Module: comparator_32x2

---
 rtl/comparator_32x2.sv | 95 +++++++++
 tb/tb_comparator_32x2.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/comparator_32x2.sv
// rtl/comparator_32x2.sv - registered signed/unsigned magnitude comparator, 1-cycle latency
// Optional CMP_UNSIGNED_SEL_EN adds is_unsigned to select an unsigned compare per operand pair.
module comparator_32x2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_UNSIGNED_SEL_EN
    input  logic             is_unsigned,
`endif
    output logic             out_valid,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NSL = (WIDTH + 3) / 4;
    localparam int PW  = NSL * 4;

    logic             w_flip;
    logic [WIDTH-1:0] w_a_k;
    logic [WIDTH-1:0] w_b_k;
    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [NSL-1:0]   w_sl_lt;
    logic [NSL-1:0]   w_sl_eq;
    logic             w_lt;
    logic             w_gt;
    logic             w_eq;
    logic             w_done;

`ifdef CMP_UNSIGNED_SEL_EN
    assign w_flip = ~is_unsigned;
`else
    assign w_flip = 1'b1;
`endif

    // Inverting both sign bits maps two's complement order onto unsigned order,
    // so the slice tree below only ever does unsigned magnitude compares.
    assign w_a_k   = {a[WIDTH-1] ^ w_flip, a[WIDTH-2:0]};
    assign w_b_k   = {b[WIDTH-1] ^ w_flip, b[WIDTH-2:0]};
    assign w_a_ext = PW'(w_a_k);
    assign w_b_ext = PW'(w_b_k);

    for (genvar s = 0; s < NSL; s++) begin : g_slice
        assign w_sl_lt[s] = w_a_ext[4*s +: 4] <  w_b_ext[4*s +: 4];
        assign w_sl_eq[s] = w_a_ext[4*s +: 4] == w_b_ext[4*s +: 4];
    end

    // The most significant unequal slice decides the result.
    always_comb begin
        w_lt   = 1'b0;
        w_gt   = 1'b0;
        w_done = 1'b0;
        for (int s = NSL - 1; s >= 0; s--) begin
            if (!w_done && !w_sl_eq[s]) begin
                w_done = 1'b1;
                w_lt   = w_sl_lt[s];
                w_gt   = ~w_sl_lt[s];
            end
        end
    end

    assign w_eq = ~w_done;

    logic r_out_valid;
    logic r_lt;
    logic r_eq;
    logic r_gt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_lt <= w_lt;
                r_eq <= w_eq;
                r_gt <= w_gt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign gt        = r_gt;

endmodule

// File: tb/tb_comparator_32x2.sv
// tb/tb_comparator_32x2.sv - scoreboard testbench for comparator_32x2
module tb_comparator_32x2;

    typedef struct {
        logic [2:0] res;
        string      tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_uns = 1'b0;
    logic        out_valid;
    logic        lt;
    logic        eq;
    logic        gt;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    logic [2:0] m_last = 3'b000;
    logic       run_mon = 1'b1;

    always #5 clk = ~clk;

    comparator_32x2 #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .a          (in_a),
        .b          (in_b),
`ifdef CMP_UNSIGNED_SEL_EN
        .is_unsigned(in_uns),
`endif
        .out_valid  (out_valid),
        .lt         (lt),
        .eq         (eq),
        .gt         (gt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [31:0] x, input logic [31:0] y, input logic uns);
        logic l;
        logic g;
        if (uns) begin
            l = x < y;
            g = x > y;
        end else begin
            l = $signed(x) < $signed(y);
            g = $signed(x) > $signed(y);
        end
        return {l, x == y, g};
    endfunction

    task automatic drive(input logic v, input logic rst, input logic [31:0] x,
                         input logic [31:0] y, input logic uns, input string tag);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        in_a     = x;
        in_b     = y;
        in_uns   = uns;
        if (v && !rst) begin
            e.res = model(x, y, uns);
            e.tag = tag;
            sb_q.push_back(e);
        end
    endtask

    // Outputs are sampled just after each rising edge; reset seen here is the value that edge captured.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (run_mon) begin
            if (reset) begin
                check("rst_out_valid", {63'd0, out_valid}, 64'd0);
                check("rst_result", {61'd0, lt, eq, gt}, 64'd0);
                m_last = 3'b000;
            end else if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, "_valid"}, {63'd0, out_valid}, 64'd1);
                check(e.tag, {61'd0, lt, eq, gt}, {61'd0, e.res});
                m_last = e.res;
            end else begin
                check("idle_out_valid", {63'd0, out_valid}, 64'd0);
                check("idle_hold", {61'd0, lt, eq, gt}, {61'd0, m_last});
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        drive(0, 1, 32'h0, 32'h0, 0, "rst");
        drive(1, 1, 32'h5, 32'h3, 0, "rst_in");
        drive(0, 0, 32'h0, 32'h0, 0, "idle");

        drive(1, 0, 32'h00000000, 32'h00000000, 0, "zero_eq");
        drive(1, 0, 32'h00001800, 32'h00000600, 0, "b2b_gt");
        drive(1, 0, 32'h00001800, 32'h00004600, 0, "b2b_lt");
        drive(1, 0, 32'hFFFF61F4, 32'h00004600, 0, "neg_lt");
        drive(1, 0, 32'h00001E0C, 32'hFFFF3A00, 0, "pos_gt");
        drive(1, 0, 32'h00001E0C, 32'h00001E0C, 0, "same_eq");
        drive(1, 0, 32'h80000000, 32'h7FFFFFFF, 0, "minmax_lt");
        drive(1, 0, 32'h80000000, 32'h80000000, 0, "min_eq");
        drive(1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, "max_eq");
        drive(1, 0, 32'h00000000, 32'hFFFFFFFF, 0, "zero_m1_gt");
        drive(1, 0, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, "neg_lsb_lt");
`ifdef CMP_UNSIGNED_SEL_EN
        drive(1, 0, 32'h80000000, 32'h7FFFFFFF, 1, "uns_gt");
        drive(1, 0, 32'h00000000, 32'hFFFFFFFF, 1, "uns_lt");
`endif
        drive(0, 0, 32'h12345678, 32'h0, 0, "idle");
        drive(0, 0, 32'h0, 32'h12345678, 0, "idle");

        // Reset mid-stream with a valid pair that must be dropped.
        drive(1, 0, 32'h00000010, 32'h00000020, 0, "pre_rst_lt");
        drive(1, 1, 32'h00000030, 32'h00000020, 0, "rst_drop");
        drive(0, 0, 32'h0, 32'h0, 0, "idle");
        drive(0, 0, 32'h0, 32'h0, 0, "idle");
        drive(1, 0, 32'h00000030, 32'h00000020, 0, "post_rst_gt");

        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0)
                drive(0, 0, ra, rb, 0, "idle");
            drive(1, 0, ra, rb, 0, "rand");
        end

        drive(0, 0, 32'h0, 32'h0, 0, "idle");
        drive(0, 0, 32'h0, 32'h0, 0, "idle");
        @(posedge clk);
        #2;
        run_mon = 1'b0;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
